// File: rtl/alu_cmd_issuer_if.sv
// ----------------------------------------------------------------------------
// alu_cmd_issuer_if
// Command and response channels of the ALU command issuer.
//
// Command channel (valid/ready, producer -> issuer):
//   cmd_valid  command present
//   cmd_ready  issuer accepts on an edge where cmd_valid & cmd_ready
//   cmd_op     4-bit ALU control code (illegal codes are filtered by the issuer)
//   cmd_a      operand A
//   cmd_b      operand B
//   cmd_tag    opaque tag echoed on the matching response
//
// Response channel (valid/ready, issuer -> consumer):
//   rsp_valid  response present at the FIFO head
//   rsp_ready  consumer takes the response on an edge where rsp_valid & rsp_ready
//   rsp_result 32-bit ALU result (0 for an illegal op)
//   rsp_zero   ALU zero flag (1 for an illegal op)
//   rsp_err    1 = the command carried an illegal op
//   rsp_tag    echoed command tag
//
// Modports: master = the client that issues commands and consumes responses,
//           slave  = the issuer itself.
// ----------------------------------------------------------------------------
interface alu_cmd_issuer_if #(
    parameter int TAG_W = 4
) ();

    logic             cmd_valid;
    logic             cmd_ready;
    logic [3:0]       cmd_op;
    logic [31:0]      cmd_a;
    logic [31:0]      cmd_b;
    logic [TAG_W-1:0] cmd_tag;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [31:0]      rsp_result;
    logic             rsp_zero;
    logic             rsp_err;
    logic [TAG_W-1:0] rsp_tag;

    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_tag, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_result, rsp_zero, rsp_err, rsp_tag
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_tag, rsp_ready,
        output cmd_ready, rsp_valid, rsp_result, rsp_zero, rsp_err, rsp_tag
    );

endinterface

// File: rtl/alu_cmd_issuer.sv
// ----------------------------------------------------------------------------
// alu_cmd_issuer
// Request-side front end for a registered 32-bit ALU. Commands arrive on a
// valid/ready channel, legal ones are driven onto the ALU inputs through
// registers, and the ALU result + zero flag are captured ALU_LAT+1 edges after
// acceptance into a response FIFO. Responses leave in command order, tagged.
// Illegal control codes never reach the ALU: the ALU sees its idle code
// 4'b1111 in that slot, and the response reports rsp_err=1, result 0, zero 1.
//
// Parameters:
//   ALU_LAT    edges from ALU input sampling to stable alu_result/alu_zero
//   RSP_DEPTH  response FIFO entries (power of 2, >= 2)
//   TAG_W      command/response tag width (must match the interface)
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-low reset
//   bus          command/response channels (slave modport)
//   alu_a_in     registered operand A to the ALU
//   alu_b_in     registered operand B to the ALU
//   alu_control  registered ALU control code (4'b1111 when idle)
//   alu_result   ALU result
//   alu_zero     ALU zero flag
//   busy         any command in flight or any response queued
//
// Flow control is credit based: a command is only accepted when the FIFO is
// guaranteed to have room for it when it reaches the end of the pipeline, so
// the FIFO can never overflow and rsp_ready never reaches cmd_ready
// combinationally.
// ----------------------------------------------------------------------------
module alu_cmd_issuer #(
    parameter int ALU_LAT   = 1,
    parameter int RSP_DEPTH = 4,
    parameter int TAG_W     = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    alu_cmd_issuer_if.slave        bus,
    output logic [31:0]            alu_a_in,
    output logic [31:0]            alu_b_in,
    output logic [3:0]             alu_control,
    input  logic [31:0]            alu_result,
    input  logic                   alu_zero,
    output logic                   busy
);

    localparam int PTR_W  = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int CNT_W  = $clog2(RSP_DEPTH + 1);
    localparam int LAST   = ALU_LAT;
    // Wide enough for fifo_count + every pipeline stage without overflow.
    localparam int CRED_W = $clog2(RSP_DEPTH + ALU_LAT + 2) + 1;

    typedef enum logic [3:0] {
        OP_AND = 4'b0000,
        OP_OR  = 4'b0001,
        OP_ADD = 4'b0010,
        OP_SLL = 4'b0011,
        OP_SUB = 4'b0100,
        OP_SRL = 4'b0101,
        OP_MUL = 4'b0110,
        OP_XOR = 4'b0111,
        OP_SLT = 4'b1000,
        OP_NOP = 4'b1111
    } alu_op_e;

    // One pipeline slot: tracks a command while the ALU works on it.
    typedef struct packed {
        logic             valid;
        logic             err;
        logic [TAG_W-1:0] tag;
    } slot_t;

    // One queued response.
    typedef struct packed {
        logic [31:0]      result;
        logic             zero;
        logic             err;
        logic [TAG_W-1:0] tag;
    } rsp_entry_t;

    function automatic logic is_legal(input logic [3:0] op);
        case (op)
            OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT,
            OP_SLL, OP_SRL, OP_MUL, OP_XOR: is_legal = 1'b1;
            default:                        is_legal = 1'b0;
        endcase
    endfunction

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    slot_t             pipe_q [0:LAST];
    rsp_entry_t        fifo_mem [RSP_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  fifo_count;
    // Holds cmd_ready low through reset and until the first edge after it.
    logic              ready_en;

    // ------------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------------
    logic [CRED_W-1:0] inflight;
    logic [CRED_W-1:0] credits_used;
    logic              cmd_ready_int;
    logic              cmd_fire;
    logic              op_legal;
    logic              push;
    logic              pop;

    // NOTE: every variable written in an always_comb gets a default at the top
    // of the block, so no path can leave it unassigned and infer a latch.
    always_comb begin
        inflight = '0;
        for (int i = 0; i <= LAST; i++) begin
            inflight = inflight + CRED_W'(pipe_q[i].valid);
        end
    end

    // Credits come from registered state only: a pop on this edge frees its
    // credit one cycle later.
    assign credits_used  = CRED_W'(fifo_count) + inflight;
    assign cmd_ready_int = ready_en && (credits_used < CRED_W'(RSP_DEPTH));
    assign cmd_fire      = bus.cmd_valid && cmd_ready_int;
    assign op_legal      = is_legal(bus.cmd_op);

    assign push = pipe_q[LAST].valid;
    assign pop  = bus.rsp_valid && bus.rsp_ready;

    assign bus.cmd_ready  = cmd_ready_int;
    assign bus.rsp_valid  = (fifo_count != '0);
    assign bus.rsp_result = fifo_mem[rd_ptr].result;
    assign bus.rsp_zero   = fifo_mem[rd_ptr].zero;
    assign bus.rsp_err    = fifo_mem[rd_ptr].err;
    assign bus.rsp_tag    = fifo_mem[rd_ptr].tag;

    assign busy = (inflight != '0) || (fifo_count != '0);

    // ------------------------------------------------------------------------
    // ALU input registers: legal commands are issued on their accept edge;
    // every other cycle (idle or illegal op) presents the ALU default arm.
    // ------------------------------------------------------------------------
    // NOTE: sequential state is always updated with non-blocking assignments so
    // every flop samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (!reset) begin
            alu_a_in    <= '0;
            alu_b_in    <= '0;
            alu_control <= OP_NOP;
        end else if (cmd_fire && op_legal) begin
            alu_a_in    <= bus.cmd_a;
            alu_b_in    <= bus.cmd_b;
            alu_control <= bus.cmd_op;
        end else begin
            alu_a_in    <= '0;
            alu_b_in    <= '0;
            alu_control <= OP_NOP;
        end
    end

    // ------------------------------------------------------------------------
    // Tracking pipeline: stage 0 is loaded on the accept edge, stage LAST
    // lines up with the edge where alu_result belongs to that command.
    // Illegal ops occupy a slot too, which keeps responses in order.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i <= LAST; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0].valid <= cmd_fire;
            pipe_q[0].err   <= cmd_fire && !op_legal;
            pipe_q[0].tag   <= bus.cmd_tag;
            for (int i = 1; i <= LAST; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Response FIFO storage
    // ------------------------------------------------------------------------
    // NOTE: the storage array has no reset; an entry is only ever read after
    // it has been written, and the pointers/count that guard it are reset.
    always_ff @(posedge clk) begin
        if (reset && push) begin
            fifo_mem[wr_ptr].result <= pipe_q[LAST].err ? 32'd0 : alu_result;
            fifo_mem[wr_ptr].zero   <= pipe_q[LAST].err ? 1'b1  : alu_zero;
            fifo_mem[wr_ptr].err    <= pipe_q[LAST].err;
            fifo_mem[wr_ptr].tag    <= pipe_q[LAST].tag;
        end
    end

    // ------------------------------------------------------------------------
    // FIFO pointers and occupancy. RSP_DEPTH is a power of 2, so the pointers
    // wrap naturally. Push and pop on one edge leave the count unchanged.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            ready_en   <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// ----------------------------------------------------------------------------
// tb_alu_cmd_issuer
// Bench for alu_cmd_issuer with a behavioural registered ALU attached.
// Stimulus pushes the hand-computed expected response into a scoreboard
// queue when a command is accepted; a monitor pops and compares every
// response the DUT hands over.
// ----------------------------------------------------------------------------
module tb_alu_cmd_issuer;

    localparam int TAG_W = 4;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SLL = 4'b0011;
    localparam logic [3:0] OP_SUB = 4'b0100;
    localparam logic [3:0] OP_SRL = 4'b0101;
    localparam logic [3:0] OP_MUL = 4'b0110;
    localparam logic [3:0] OP_XOR = 4'b0111;
    localparam logic [3:0] OP_SLT = 4'b1000;
    localparam logic [3:0] OP_BAD = 4'b1111;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    alu_cmd_issuer_if #(.TAG_W(TAG_W)) ifc ();

    logic [31:0] alu_a_in;
    logic [31:0] alu_b_in;
    logic [3:0]  alu_control;
    logic [31:0] alu_result;
    logic        alu_zero;
    logic        busy;

    alu_cmd_issuer #(
        .ALU_LAT   (1),
        .RSP_DEPTH (4),
        .TAG_W     (TAG_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (ifc),
        .alu_a_in    (alu_a_in),
        .alu_b_in    (alu_b_in),
        .alu_control (alu_control),
        .alu_result  (alu_result),
        .alu_zero    (alu_zero),
        .busy        (busy)
    );

    // ------------------------------------------------------------------------
    // Registered ALU, reset active-high from ~reset.
    // ------------------------------------------------------------------------
    logic alu_rst;
    assign alu_rst = ~reset;

    function automatic logic [31:0] alu_fn(input logic [3:0] c, input logic [31:0] a,
                                           input logic [31:0] b);
        case (c)
            OP_AND:  alu_fn = a & b;
            OP_OR:   alu_fn = a | b;
            OP_ADD:  alu_fn = a + b;
            OP_SUB:  alu_fn = a - b;
            OP_SLT:  alu_fn = (a < b) ? 32'd1 : 32'd0;
            OP_SLL:  alu_fn = a << b;
            OP_SRL:  alu_fn = a >> b;
            OP_MUL:  alu_fn = a * b;
            OP_XOR:  alu_fn = a ^ b;
            default: alu_fn = 32'd0;
        endcase
    endfunction

    always @(posedge clk) begin
        if (alu_rst) begin
            alu_result <= 32'd0;
            alu_zero   <= 1'b1;
        end else begin
            alu_result <= alu_fn(alu_control, alu_a_in, alu_b_in);
            alu_zero   <= (alu_fn(alu_control, alu_a_in, alu_b_in) == 32'd0);
        end
    end

    // ------------------------------------------------------------------------
    // Scoreboard and counters
    // ------------------------------------------------------------------------
    typedef struct packed {
        logic [31:0]      res;
        logic             zero;
        logic             err;
        logic [TAG_W-1:0] tag;
    } exp_t;

    exp_t sb[$];
    int   n_vec  = 0;
    int   n_miss = 0;
    int   n_rsp  = 0;

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        n_vec++;
        if (actual !== expected) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, actual, expected);
        end
    endtask

    task automatic flag(input string name, input string detail);
        n_vec++;
        n_miss++;
        $display("FAIL %s: %s", name, detail);
    endtask

    task automatic expect_rsp(input logic [31:0] res, input logic zero, input logic err,
                              input logic [TAG_W-1:0] tag);
        exp_t e;
        e.res  = res;
        e.zero = zero;
        e.err  = err;
        e.tag  = tag;
        sb.push_back(e);
    endtask

    // Monitor: a handshake seen at the negedge completes on the next posedge.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset && ifc.rsp_valid && ifc.rsp_ready) begin
                n_rsp++;
                if (sb.size() == 0) begin
                    flag("unexpected_rsp",
                         $sformatf("got tag %0d result 0x%08h, want no response",
                                   ifc.rsp_tag, ifc.rsp_result));
                end else begin
                    e = sb.pop_front();
                    check($sformatf("rsp_tag(exp %0d)",    e.tag), 32'(ifc.rsp_tag), 32'(e.tag));
                    check($sformatf("rsp_result(tag %0d)", e.tag), ifc.rsp_result,   e.res);
                    check($sformatf("rsp_zero(tag %0d)",   e.tag), 32'(ifc.rsp_zero), 32'(e.zero));
                    check($sformatf("rsp_err(tag %0d)",    e.tag), 32'(ifc.rsp_err),  32'(e.err));
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers. Inputs change 1 ns after a posedge.
    // ------------------------------------------------------------------------
    task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [TAG_W-1:0] tag, input logic [31:0] res,
                        input logic zero, input logic err);
        bit done;
        done          = 1'b0;
        ifc.cmd_valid = 1'b1;
        ifc.cmd_op    = op;
        ifc.cmd_a     = a;
        ifc.cmd_b     = b;
        ifc.cmd_tag   = tag;
        for (int n = 0; n < 50 && !done; n++) begin
            @(negedge clk);
            if (ifc.cmd_ready) begin
                expect_rsp(res, zero, err, tag);
                @(posedge clk);
                #1;
                done = 1'b1;
            end
        end
        ifc.cmd_valid = 1'b0;
        if (!done) flag("send_timeout", $sformatf("got no accept for tag %0d, want accept", tag));
    endtask

    // Streams ADD (a=i, b=100) or MUL (a=i, b=3) commands tagged i, i=acc..total-1.
    task automatic stream(input int total, input logic [3:0] op, input int cycles,
                          input bit record, input bit req_ready, inout int acc);
        logic [31:0] res;
        for (int c = 0; c < cycles && acc < total; c++) begin
            ifc.cmd_valid = 1'b1;
            ifc.cmd_op    = op;
            ifc.cmd_a     = 32'(acc);
            ifc.cmd_b     = (op == OP_MUL) ? 32'd3 : 32'd100;
            ifc.cmd_tag   = acc[TAG_W-1:0];
            res           = (op == OP_MUL) ? 32'(acc * 3) : 32'(acc + 100);
            @(negedge clk);
            if (req_ready) check($sformatf("t5_cmd_ready(i=%0d)", acc), 32'(ifc.cmd_ready), 32'd1);
            if (ifc.cmd_ready) begin
                if (record) expect_rsp(res, (res == 32'd0), 1'b0, acc[TAG_W-1:0]);
                acc++;
            end
            @(posedge clk);
            #1;
        end
        ifc.cmd_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        bit done;
        done = 1'b0;
        for (int n = 0; n < 100 && !done; n++) begin
            @(negedge clk);
            if (sb.size() == 0 && !busy) done = 1'b1;
        end
        if (!done) flag(name, $sformatf("got %0d responses pending busy=%0b, want drained",
                                        sb.size(), busy));
        @(posedge clk);
        #1;
    endtask

    // T1: single ADD with latency checks around the accept edge k.
    task automatic run_t1(input string name);
        ifc.rsp_ready = 1'b1;
        send(OP_ADD, 32'd5, 32'd7, 4'd3, 32'd12, 1'b0, 1'b0);
        check({name, "_control_k"}, 32'(alu_control), 32'(OP_ADD));
        check({name, "_valid_k"},   32'(ifc.rsp_valid), 32'd0);
        @(posedge clk); #1;
        check({name, "_valid_k1"},  32'(ifc.rsp_valid), 32'd0);
        @(posedge clk); #1;
        check({name, "_valid_k2"},  32'(ifc.rsp_valid), 32'd1);
        wait_drain({name, "_drain"});
    endtask

    // ------------------------------------------------------------------------
    // Directed vectors for the op mix (T2 and boundaries)
    // ------------------------------------------------------------------------
    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        zero;
    } vec_t;

    vec_t vecs [12];

    initial begin : stimulus
        int acc;
        int rsp0;

        vecs = '{
            '{OP_SUB, 32'h10,       32'h10,     32'h0,        1'b1},
            '{OP_SLT, 32'd1,        32'd2,      32'd1,        1'b0},
            '{OP_OR,  32'hA,        32'h5,      32'hF,        1'b0},
            '{OP_SLL, 32'd1,        32'd4,      32'h10,       1'b0},
            '{OP_SRL, 32'h80,       32'd3,      32'h10,       1'b0},
            '{OP_XOR, 32'hFF,       32'h0F,     32'hF0,       1'b0},
            '{OP_SLT, 32'hFFFFFFFF, 32'd1,      32'd0,        1'b1},
            '{OP_ADD, 32'hFFFFFFFF, 32'd1,      32'd0,        1'b1},
            '{OP_SLL, 32'd1,        32'd32,     32'd0,        1'b1},
            '{OP_MUL, 32'h10000,    32'h10000,  32'd0,        1'b1},
            '{OP_SUB, 32'd3,        32'd5,      32'hFFFFFFFE, 1'b0},
            '{OP_MUL, 32'd7,        32'd6,      32'd42,       1'b0}
        };

        ifc.cmd_valid = 1'b0;
        ifc.cmd_op    = '0;
        ifc.cmd_a     = '0;
        ifc.cmd_b     = '0;
        ifc.cmd_tag   = '0;
        ifc.rsp_ready = 1'b1;

        // Reset state
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cmd_ready",   32'(ifc.cmd_ready), 32'd0);
        check("rst_rsp_valid",   32'(ifc.rsp_valid), 32'd0);
        check("rst_busy",        32'(busy),          32'd0);
        check("rst_alu_control", 32'(alu_control),   32'hF);
        check("rst_alu_a_in",    alu_a_in,           32'd0);
        check("rst_alu_b_in",    alu_b_in,           32'd0);
        reset = 1'b1;
        check("rel_cmd_ready_pre",  32'(ifc.cmd_ready), 32'd0);
        @(posedge clk); #1;
        check("rel_cmd_ready_post", 32'(ifc.cmd_ready), 32'd1);

        // T1
        run_t1("t1");

        // T2 and op mix, back-to-back
        for (int i = 0; i < 12; i++) begin
            send(vecs[i].op, vecs[i].a, vecs[i].b, 4'(i), vecs[i].res, vecs[i].zero, 1'b0);
        end
        wait_drain("t2_drain");

        // T3: AND, illegal, AND
        send(OP_AND, 32'hF0F0, 32'hFF00, 4'd1, 32'hF000, 1'b0, 1'b0);
        check("t3_and0_control", 32'(alu_control), 32'(OP_AND));
        check("t3_and0_a",       alu_a_in,         32'hF0F0);
        send(OP_BAD, 32'h1234, 32'h5678, 4'd9, 32'd0, 1'b1, 1'b1);
        check("t3_bad_control",  32'(alu_control), 32'hF);
        check("t3_bad_a",        alu_a_in,         32'd0);
        send(OP_AND, 32'h0F, 32'hF0, 4'd2, 32'd0, 1'b1, 1'b0);
        check("t3_and1_control", 32'(alu_control), 32'(OP_AND));
        wait_drain("t3_drain");

        // T4: back-pressure
        ifc.rsp_ready = 1'b0;
        acc = 0;
        stream(10, OP_ADD, 20, 1'b1, 1'b0, acc);
        check("t4_accepted",    32'(acc),           32'd4);
        check("t4_cmd_ready",   32'(ifc.cmd_ready), 32'd0);
        check("t4_busy",        32'(busy),          32'd1);
        check("t4_rsp_valid",   32'(ifc.rsp_valid), 32'd1);
        rsp0 = n_rsp;
        ifc.rsp_ready = 1'b1;
        stream(10, OP_ADD, 100, 1'b1, 1'b0, acc);
        check("t4_accepted_all", 32'(acc), 32'd10);
        wait_drain("t4_drain");
        check("t4_rsp_count", 32'(n_rsp - rsp0), 32'd10);

        // T5: full throughput
        acc  = 0;
        rsp0 = n_rsp;
        stream(16, OP_MUL, 16, 1'b1, 1'b1, acc);
        check("t5_accepted", 32'(acc), 32'd16);
        wait_drain("t5_drain");
        check("t5_rsp_count", 32'(n_rsp - rsp0), 32'd16);

        // T6: reset with 2 in flight and 2 queued; those responses are discarded
        ifc.rsp_ready = 1'b0;
        acc = 0;
        stream(4, OP_ADD, 4, 1'b0, 1'b0, acc);
        check("t6_accepted",  32'(acc),           32'd4);
        check("t6_pre_busy",  32'(busy),          32'd1);
        check("t6_pre_valid", 32'(ifc.rsp_valid), 32'd1);
        reset = 1'b0;
        @(posedge clk); #1;
        check("t6_rst_valid",     32'(ifc.rsp_valid), 32'd0);
        check("t6_rst_busy",      32'(busy),          32'd0);
        check("t6_rst_cmd_ready", 32'(ifc.cmd_ready), 32'd0);
        check("t6_rst_control",   32'(alu_control),   32'hF);
        reset = 1'b1;
        @(posedge clk); #1;
        check("t6_rel_cmd_ready", 32'(ifc.cmd_ready), 32'd1);
        ifc.rsp_ready = 1'b1;
        rsp0 = n_rsp;
        repeat (8) @(posedge clk);
        #1;
        check("t6_no_stale", 32'(n_rsp - rsp0), 32'd0);
        check("t6_idle_busy", 32'(busy), 32'd0);
        run_t1("t6_t1");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
